mem_read_responder: RTL
=======================

Name: mem_read_responder

Overview:
- Memory-side responder for the accelerator's unified read request stream (MEM_read_en / MEM_read_addr).
- Queues each request and decodes it into the iact (DRAM) or weight (ROM) region.
- Fetches the word over an external req/gnt/rvalid bus that may stall, and returns the data in request order on typed, validated output channels.
- Sits between the TOP core and off-chip storage, and replaces fixed one-cycle ROM/DRAM timing.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of two, at least 2)
- ADDR_W, 16, width of request and external addresses
- IACT_DATA_END, 784, first unified address belonging to ROM; addresses below it are DRAM

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- MEM_read_en  in  1  read request strobe, one request per cycle
- MEM_read_addr  in  ADDR_W  unified read address
- MEM_stall  out  1  high when the request FIFO is full
- ext_req  out  1  external read request, held until granted
- ext_sel  out  1  0 selects DRAM, 1 selects ROM; stable while ext_req is high
- ext_addr  out  ADDR_W  local address: DRAM address, or unified address minus IACT_DATA_END
- ext_gnt  in  1  external bus accepted the request
- ext_rvalid  in  1  read data valid, at least 1 cycle after the grant
- ext_rdata  in  16  read data
- iact_out  out  8  ext_rdata[7:0]
- iact_out_valid  out  1  one-cycle pulse
- weight_addr_out  out  8  ext_rdata[7:0]
- weight_addr_out_valid  out  1  one-cycle pulse
- weight_data_out  out  13  ext_rdata[12:0]
- weight_data_out_valid  out  1  one-cycle pulse
- overflow_err  out  1  sticky; a request was dropped
- range_err  out  1  sticky; a request was out of range

Behaviour:
- Reset clears all outputs to 0, empties the FIFO and puts the FSM in IDLE. This applies mid-transaction too:
  - ext_req drops in the cycle after reset.
  - An ext_rvalid arriving after reset is ignored and produces no output.
- Push: MEM_read_en is high and either the FIFO is not full or a pop happens in the same cycle.
  - Each entry stores {addr, class}.
  - The class is decoded at push time.
- Push while full with no pop: the request is dropped, overflow_err is set, and the FIFO is unchanged.
- Class decode, with r = addr - IACT_DATA_END:
  - addr < IACT_DATA_END: IACT.
  - r falls in a ROM weight-address segment: WADDR.
  - r falls in a ROM weight-data segment: WDATA.
  - r >= ROM_END: INVALID.
- INVALID entries are popped in IDLE without any external access. They set range_err and produce no valid pulse, costing 1 cycle.
- FSM:
  - IDLE: if the FIFO is non-empty and the head is valid, go to ISSUE. The head is not popped yet.
  - ISSUE: ext_req=1, with ext_sel and ext_addr taken from the head. On ext_gnt, pop the head, latch its class and go to WAIT.
  - WAIT: ext_req=0. On ext_rvalid, register the data into the output channel selected by the latched class, pulse that channel's valid for 1 cycle and return to IDLE.
- Only one transaction is outstanding. Responses are strictly in request order.
- Minimum latency: request accepted at edge N, ext_req high in cycle N+1, gnt in N+1, rvalid in N+2, output valid in N+3.
- An ext_rvalid outside WAIT is ignored.
- At most one output valid is high in any cycle. Data buses hold their last value while the valid is low.
- MEM_stall is combinational from FIFO full.
- Push and pop in the same cycle keep the count unchanged, including when the FIFO is full.

Decomposition:
- Shared package mem_map_pkg holds:
  - IACT_DATA_END.
  - The ROM segment ends 7, 125, 179, 968, 1022, 1813, 9973, 29835, 32481, 39093, 39357, 39978 (ROM_END = 39978).
  - The 2-bit class enum: IACT, WADDR, WDATA, INVALID.
  - A classify function that returns the class for a unified address.
- Even-indexed ends close weight-address segments; odd-indexed ends close weight-data segments.
- One sub-module: req_fifo, a synchronous FIFO parameterised on width and depth, with full/empty flags and simultaneous push/pop.

Test Plan:
- addr 100; gnt immediate; rvalid one cycle later with 0x00A5 -> iact_out=0xA5 with valid at N+3; ext_sel=0; ext_addr=100.
- addr 784+3 with rdata 0x1234 -> ext_sel=1, ext_addr=3, weight_addr_out=0x34 valid; addr 784+50 with rdata 0x1FFF -> weight_data_out=0x1FFF valid.
- Back-to-back requests to 10, 11, 12, 13, 14 with gnt held low for 20 cycles -> MEM_stall high after 4 queued; the 5th request is dropped and overflow_err=1; the first 4 complete in order.
- addr 784+39978 -> no ext_req, no valid pulse, range_err=1; the next valid request is still served.
- Reset asserted in WAIT, then a late rvalid -> all outputs 0 and no valid pulse; a new request afterwards completes normally.
- Request at full with simultaneous gnt pop -> accepted, count stays 4, overflow_err stays 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Unified read address map shared by the TOP core and the memory responder:
// the iact/ROM split point, ROM segment boundaries and the address class decode.
package mem_map_pkg;

    localparam int unsigned IACT_DATA_END = 784;
    localparam int          ROM_SEG_N     = 12;
    localparam int unsigned ROM_END       = 39978;

    // Even-indexed ends close weight-address segments, odd-indexed ones weight-data segments.
    localparam logic [0:ROM_SEG_N-1][31:0] ROM_SEG_ENDS = '{
        32'd7,    32'd125,  32'd179,   32'd968,   32'd1022,  32'd1813,
        32'd9973, 32'd29835, 32'd32481, 32'd39093, 32'd39357, 32'd39978
    };

    typedef enum logic [1:0] {
        CLS_IACT    = 2'd0,
        CLS_WADDR   = 2'd1,
        CLS_WDATA   = 2'd2,
        CLS_INVALID = 2'd3
    } mem_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } rsp_state_e;

    function automatic mem_class_e classify(input logic [31:0] addr, input logic [31:0] iact_end);
        mem_class_e  cls;
        logic [31:0] r;
        logic        found;
        cls   = CLS_INVALID;
        found = 1'b0;
        r     = addr - iact_end;
        if (addr < iact_end) begin
            cls = CLS_IACT;
        end else begin
            for (int i = 0; i < ROM_SEG_N; i++) begin
                if (!found && (r < ROM_SEG_ENDS[i])) begin
                    found = 1'b1;
                    cls   = ((i % 2) == 0) ? CLS_WADDR : CLS_WDATA;
                end
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/mem_read_responder_req_fifo.sv
// Synchronous request FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle, so the count stays unchanged.
module req_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries below count_q are ever read out.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side responder: queues unified read requests, fetches each over the
// stallable req/gnt/rvalid bus and returns data in order on typed channels.
module mem_read_responder #(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          ADDR_W        = 16,
    parameter int unsigned IACT_DATA_END = mem_map_pkg::IACT_DATA_END
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MEM_read_en,
    input  logic [ADDR_W-1:0] MEM_read_addr,
    output logic              MEM_stall,
    output logic              ext_req,
    output logic              ext_sel,
    output logic [ADDR_W-1:0] ext_addr,
    input  logic              ext_gnt,
    input  logic              ext_rvalid,
    input  logic [15:0]       ext_rdata,
    output logic [7:0]        iact_out,
    output logic              iact_out_valid,
    output logic [7:0]        weight_addr_out,
    output logic              weight_addr_out_valid,
    output logic [12:0]       weight_data_out,
    output logic              weight_data_out_valid,
    output logic              overflow_err,
    output logic              range_err
);
    import mem_map_pkg::*;

    localparam int EW = ADDR_W + 2;

    rsp_state_e        state_q, state_d;
    mem_class_e        cls_q, cls_d;
    mem_class_e        push_cls, head_cls;
    logic [ADDR_W-1:0] head_addr;
    logic [EW-1:0]     fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              range_hit, drop, rsp_fire;
    logic [7:0]        iact_q, waddr_q;
    logic [12:0]       wdata_q;
    logic              iact_v_q, waddr_v_q, wdata_v_q, ovf_q, rng_q;
    logic              unused_rdata;

    // Class is decoded once at push so the head decision in IDLE is a plain compare.
    assign push_cls  = classify(32'(MEM_read_addr), 32'(IACT_DATA_END));
    assign head_addr = fifo_rdata[EW-1:2];
    assign head_cls  = mem_class_e'(fifo_rdata[1:0]);
    assign fifo_push = MEM_read_en && (!fifo_full || fifo_pop);
    assign drop      = MEM_read_en && fifo_full && !fifo_pop;
    assign MEM_stall = fifo_full;
    assign rsp_fire  = (state_q == ST_WAIT) && ext_rvalid;
    assign unused_rdata = ^ext_rdata[15:13];

    req_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i ({MEM_read_addr, push_cls}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        fifo_pop  = 1'b0;
        range_hit = 1'b0;
        ext_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_cls == CLS_INVALID) begin
                        fifo_pop  = 1'b1;
                        range_hit = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                ext_req = 1'b1;
                if (ext_gnt) begin
                    fifo_pop = 1'b1;
                    cls_d    = head_cls;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ext_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select and address are forced to zero outside ISSUE so they never show stale heads.
    assign ext_sel  = ext_req && (head_cls != CLS_IACT);
    assign ext_addr = !ext_req ? '0 :
                      (head_cls == CLS_IACT) ? head_addr : head_addr - ADDR_W'(IACT_DATA_END);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_IACT;
            iact_q    <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            iact_v_q  <= 1'b0;
            waddr_v_q <= 1'b0;
            wdata_v_q <= 1'b0;
            ovf_q     <= 1'b0;
            rng_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            iact_v_q  <= rsp_fire && (cls_q == CLS_IACT);
            waddr_v_q <= rsp_fire && (cls_q == CLS_WADDR);
            wdata_v_q <= rsp_fire && (cls_q == CLS_WDATA);
            if (rsp_fire && (cls_q == CLS_IACT))  iact_q  <= ext_rdata[7:0];
            if (rsp_fire && (cls_q == CLS_WADDR)) waddr_q <= ext_rdata[7:0];
            if (rsp_fire && (cls_q == CLS_WDATA)) wdata_q <= ext_rdata[12:0];
            ovf_q     <= ovf_q | drop;
            rng_q     <= rng_q | range_hit;
        end
    end

    assign iact_out              = iact_q;
    assign iact_out_valid        = iact_v_q;
    assign weight_addr_out       = waddr_q;
    assign weight_addr_out_valid = waddr_v_q;
    assign weight_data_out       = wdata_q;
    assign weight_data_out_valid = wdata_v_q;
    assign overflow_err          = ovf_q;
    assign range_err             = rng_q;

endmodule
